pwl_activation_engine: RTL and testbench



---
 rtl/pwl_activation_engine.sv | 207 ++++++++++++++++++++
 tb/tb_pwl_activation_engine.sv | 344 ++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/pwl_activation_engine.sv
// Streaming per-lane activation engine: ReLU, bypass, or piecewise-linear from
// one of N_FUNC programmable coefficient banks, one memory word per cycle.
module pwl_activation_engine #(
    parameter int N_LANES = 4,
    parameter int DATA_W  = 8,
    parameter int ADDR_W  = 14,
    parameter int N_SEG   = 8,
    parameter int N_FUNC  = 2,
    localparam int BANK_W = (N_FUNC > 1) ? $clog2(N_FUNC) : 1,
    localparam int LUT_AW = $clog2(N_FUNC * (4 + 3 * N_SEG))
) (
    input  logic                        clk,
    input  logic                        reset,
    input  logic                        start,
    input  logic [15:0]                 num_words,
    input  logic [ADDR_W-1:0]           rd_base_addr,
    input  logic [ADDR_W-1:0]           wr_base_addr,
    input  logic [1:0]                  mode,
    input  logic [BANK_W-1:0]           bank_sel,
    input  logic [3:0]                  frac_shift,
    input  logic                        lut_wr_en,
    input  logic [LUT_AW-1:0]           lut_wr_addr,
    input  logic signed [DATA_W-1:0]    lut_wr_data,
    output logic                        rd_en,
    output logic [ADDR_W-1:0]           rd_addr,
    input  logic [N_LANES*DATA_W-1:0]   read_word,
    output logic                        wr_en,
    output logic [ADDR_W-1:0]           wr_addr,
    output logic [N_LANES*DATA_W-1:0]   output_word,
    output logic                        busy,
    output logic                        done
);

    localparam int BANK_SZ   = 4 + 3 * N_SEG;
    localparam int N_ENTRIES = N_FUNC * BANK_SZ;
    localparam int SEG_W     = (N_SEG > 1) ? $clog2(N_SEG) : 1;
    localparam int SW        = 2 * DATA_W + 16;
    localparam logic [ADDR_W-1:0] STEP   = ADDR_W'(N_LANES);
    localparam logic signed [SW-1:0] SAT_HI = SW'((1 << (DATA_W - 1)) - 1);
    localparam logic signed [SW-1:0] SAT_LO = -SAT_HI - SW'(1);

    typedef enum logic [1:0] {S_IDLE, S_RUN, S_DRAIN, S_DONE} state_t;

    state_t                   state;
    logic [15:0]              num_q;
    logic [15:0]              rd_cnt;
    logic [1:0]               mode_q;
    logic [BANK_W-1:0]        bank_q;
    logic [3:0]               shift_q;
    logic [ADDR_W-1:0]        wr_ptr;
    logic                     pipe_v;
    logic [N_LANES*DATA_W-1:0] result;

    logic signed [DATA_W-1:0] tbl [N_ENTRIES];
    logic signed [DATA_W-1:0] x_min, x_max, y_min, y_max;
    logic signed [DATA_W-1:0] xb [N_SEG];
    logic signed [DATA_W-1:0] sa [N_SEG];
    logic signed [DATA_W-1:0] sb [N_SEG];
    int                       bank_base;

    function automatic logic signed [SW-1:0] sext(input logic signed [DATA_W-1:0] v);
        return {{(SW - DATA_W){v[DATA_W-1]}}, v};
    endfunction

    // NOTE: sequential state uses non-blocking assignments so every register
    // samples pre-edge values regardless of block ordering.
    always_ff @(posedge clk) begin
        if (reset) begin
            state   <= S_IDLE;
            busy    <= 1'b0;
            done    <= 1'b0;
            rd_en   <= 1'b0;
            rd_addr <= '0;
            rd_cnt  <= '0;
            num_q   <= '0;
            mode_q  <= '0;
            bank_q  <= '0;
            shift_q <= '0;
            wr_ptr  <= '0;
        end else begin
            case (state)
                S_IDLE: begin
                    done <= 1'b0;
                    if (start) begin
                        num_q   <= num_words;
                        mode_q  <= mode;
                        bank_q  <= bank_sel;
                        shift_q <= frac_shift;
                        wr_ptr  <= wr_base_addr;
                        if (num_words == 16'd0) begin
                            state <= S_DONE;
                            done  <= 1'b1;
                        end else begin
                            state   <= S_RUN;
                            busy    <= 1'b1;
                            rd_en   <= 1'b1;
                            rd_addr <= rd_base_addr;
                            rd_cnt  <= 16'd1;
                        end
                    end
                end
                S_RUN: begin
                    if (pipe_v) wr_ptr <= wr_ptr + STEP;
                    // rd_cnt counts reads already on the port, including this cycle's
                    if (rd_cnt == num_q) begin
                        rd_en <= 1'b0;
                        state <= S_DRAIN;
                    end else begin
                        rd_addr <= rd_addr + STEP;
                        rd_cnt  <= rd_cnt + 16'd1;
                    end
                end
                S_DRAIN: begin
                    if (pipe_v) wr_ptr <= wr_ptr + STEP;
                    if (wr_en && !pipe_v) begin
                        state <= S_DONE;
                        busy  <= 1'b0;
                        done  <= 1'b1;
                    end
                end
                default: begin
                    done  <= 1'b0;
                    state <= S_IDLE;
                end
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            // NOTE: the coefficient store is reset explicitly because a cleared
            // table is part of the block's defined post-reset behaviour.
            for (int i = 0; i < N_ENTRIES; i++) tbl[i] <= '0;
        end else if (lut_wr_en && !busy &&
                     ({1'b0, lut_wr_addr} < (LUT_AW + 1)'(N_ENTRIES))) begin
            tbl[lut_wr_addr] <= lut_wr_data;
        end
    end

    always_comb begin
        bank_base = (int'(bank_q) < N_FUNC) ? int'(bank_q) * BANK_SZ : 0;
        x_min = tbl[LUT_AW'(bank_base)];
        x_max = tbl[LUT_AW'(bank_base + 1)];
        y_min = tbl[LUT_AW'(bank_base + 2)];
        y_max = tbl[LUT_AW'(bank_base + 3)];
        for (int i = 0; i < N_SEG; i++) begin
            xb[i] = tbl[LUT_AW'(bank_base + 4 + i)];
            sa[i] = tbl[LUT_AW'(bank_base + 4 + N_SEG + i)];
            sb[i] = tbl[LUT_AW'(bank_base + 4 + 2 * N_SEG + i)];
        end
    end

    always_comb begin : lane_math
        logic signed [DATA_W-1:0] x;
        logic signed [DATA_W-1:0] y;
        logic [SEG_W-1:0]         idx;
        logic signed [SW-1:0]     s;
        logic signed [SW-1:0]     q;
        // NOTE: every variable gets a default before any branch so no path
        // leaves it unassigned, which would otherwise infer a latch.
        result = '0;
        x = '0; y = '0; idx = '0; s = '0; q = '0;
        for (int l = 0; l < N_LANES; l++) begin
            x   = read_word[l*DATA_W +: DATA_W];
            y   = x;
            idx = '0;
            s   = '0;
            q   = '0;
            if (mode_q == 2'd0) begin
                if (x[DATA_W-1]) y = '0;
            end else if (mode_q == 2'd1) begin
                if (x <= x_min) begin
                    y = y_min;
                end else if (x >= x_max) begin
                    y = y_max;
                end else begin
                    for (int i = 0; i < N_SEG; i++)
                        if (x >= xb[i]) idx = SEG_W'(i);
                    s = sext(sa[idx]) * sext(x) + (sext(sb[idx]) <<< shift_q);
                    q = s >>> shift_q;
                    if (q > SAT_HI)      y = SAT_HI[DATA_W-1:0];
                    else if (q < SAT_LO) y = SAT_LO[DATA_W-1:0];
                    else                 y = q[DATA_W-1:0];
                end
            end
            result[l*DATA_W +: DATA_W] = y;
        end
    end

    // pipe_v marks read_word valid this cycle; results land one edge later
    always_ff @(posedge clk) begin
        if (reset) begin
            pipe_v      <= 1'b0;
            wr_en       <= 1'b0;
            wr_addr     <= '0;
            output_word <= '0;
        end else begin
            pipe_v <= rd_en;
            wr_en  <= pipe_v;
            if (pipe_v) begin
                wr_addr     <= wr_ptr;
                output_word <= result;
            end
        end
    end

endmodule

// File: tb/tb_pwl_activation_engine.sv
// Self-checking bench for pwl_activation_engine: randomized runs compared
// cycle by cycle against an arithmetic model of the activation functions.
module tb_pwl_activation_engine;

    localparam int NL  = 4;
    localparam int NS  = 8;
    localparam int NF  = 2;
    localparam int BSZ = 4 + 3 * NS;

    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic        start = 1'b0;
    logic [15:0] num_words = '0;
    logic [13:0] rd_base_addr = '0;
    logic [13:0] wr_base_addr = '0;
    logic [1:0]  mode = '0;
    logic [0:0]  bank_sel = '0;
    logic [3:0]  frac_shift = '0;
    logic        lut_wr_en = 1'b0;
    logic [5:0]  lut_wr_addr = '0;
    logic [7:0]  lut_wr_data = '0;
    logic        rd_en;
    logic [13:0] rd_addr;
    logic [31:0] read_word = '0;
    logic        wr_en;
    logic [13:0] wr_addr;
    logic [31:0] output_word;
    logic        busy;
    logic        done;

    pwl_activation_engine dut (
        .clk(clk), .reset(reset), .start(start), .num_words(num_words),
        .rd_base_addr(rd_base_addr), .wr_base_addr(wr_base_addr),
        .mode(mode), .bank_sel(bank_sel), .frac_shift(frac_shift),
        .lut_wr_en(lut_wr_en), .lut_wr_addr(lut_wr_addr), .lut_wr_data(lut_wr_data),
        .rd_en(rd_en), .rd_addr(rd_addr), .read_word(read_word),
        .wr_en(wr_en), .wr_addr(wr_addr), .output_word(output_word),
        .busy(busy), .done(done)
    );

    always #5 clk = ~clk;

    logic [31:0] mem [16384];
    always @(posedge clk) if (rd_en) read_word <= mem[rd_addr];

    int          tbl_m [NF][BSZ];
    int          n_checks = 0;
    int          n_fail = 0;
    logic [31:0] last_out = '0;

    function automatic int model_lane(int md, int bk, int fs, int x);
        int idx;
        longint s, d, q;
        if (md == 0) return (x > 0) ? x : 0;
        if (md != 1) return x;
        if (x <= tbl_m[bk][0]) return tbl_m[bk][2];
        if (x >= tbl_m[bk][1]) return tbl_m[bk][3];
        idx = 0;
        for (int i = 0; i < NS; i++) if (x >= tbl_m[bk][4+i]) idx = i;
        d = longint'(1) << fs;
        s = longint'(tbl_m[bk][4+NS+idx]) * x + longint'(tbl_m[bk][4+2*NS+idx]) * d;
        q = s / d;
        if ((s % d != 0) && (s < 0)) q = q - 1;
        if (q > 127) return 127;
        if (q < -128) return -128;
        return int'(q);
    endfunction

    function automatic logic [31:0] model_word(int md, int bk, int fs, logic [31:0] w);
        logic [31:0]       r;
        logic signed [7:0] b;
        int                y;
        r = '0;
        for (int l = 0; l < NL; l++) begin
            b = w[l*8 +: 8];
            y = model_lane(md, bk, fs, int'(b));
            r[l*8 +: 8] = y[7:0];
        end
        return r;
    endfunction

    function automatic int rand_s8();
        return int'($urandom_range(0, 255)) - 128;
    endfunction

    task automatic lut_write(input int addr, input int val);
        @(negedge clk);
        lut_wr_en   = 1'b1;
        lut_wr_addr = addr[5:0];
        lut_wr_data = val[7:0];
        @(negedge clk);
        lut_wr_en = 1'b0;
        if (addr < NF * BSZ) tbl_m[addr / BSZ][addr % BSZ] = val;
    endtask

    task automatic rand_bank(input int bk);
        lut_write(bk*BSZ + 0, -int'($urandom_range(60, 128)));
        lut_write(bk*BSZ + 1, int'($urandom_range(60, 127)));
        lut_write(bk*BSZ + 2, rand_s8());
        lut_write(bk*BSZ + 3, rand_s8());
        for (int i = 0; i < NS; i++) begin
            lut_write(bk*BSZ + 4 + i, -96 + 24*i + int'($urandom_range(0, 10)));
            lut_write(bk*BSZ + 4 + NS + i, rand_s8());
            lut_write(bk*BSZ + 4 + 2*NS + i, rand_s8());
        end
    endtask

    // One complete run, checked every cycle from the start edge until IDLE again
    task automatic run_job(input int n, input int rb, input int wb, input int md,
                           input int bk, input int fs, input bit disturb);
        logic [3:0]  e_ctrl, g_ctrl;
        logic [13:0] ea;
        logic [31:0] ew;
        int          k;
        @(negedge clk);
        num_words    = n[15:0];
        rd_base_addr = rb[13:0];
        wr_base_addr = wb[13:0];
        mode         = md[1:0];
        bank_sel     = bk[0:0];
        frac_shift   = fs[3:0];
        start        = 1'b1;
        for (int rel = 1; rel <= n + 4; rel++) begin
            @(negedge clk);
            if (rel == 1) start = 1'b0;
            if (disturb && rel == 2) begin
                start        = 1'b1;
                mode         = mode ^ 2'b01;
                bank_sel     = ~bank_sel;
                frac_shift   = 4'($urandom);
                num_words    = 16'($urandom);
                rd_base_addr = 14'($urandom);
                wr_base_addr = 14'($urandom);
                lut_wr_en    = 1'b1;
                lut_wr_addr  = 6'(BSZ + 1);
                lut_wr_data  = 8'd10;
            end
            if (disturb && rel == 3) begin
                start     = 1'b0;
                lut_wr_en = 1'b0;
            end
            e_ctrl = {rel <= n, n > 0 && rel <= n + 2,
                      rel == ((n == 0) ? 1 : n + 3), rel >= 3 && rel <= n + 2};
            g_ctrl = {rd_en, busy, done, wr_en};
            n_checks++;
            if (g_ctrl !== e_ctrl) begin
                n_fail++;
                $display("FAIL ctrl rel=%0d n=%0d rd/busy/done/wr got=%b exp=%b", rel, n, g_ctrl, e_ctrl);
            end
            if (rel <= n) begin
                ea = 14'(rb + (rel - 1) * 4);
                n_checks++;
                if (rd_addr !== ea) begin
                    n_fail++;
                    $display("FAIL rd_addr rel=%0d got=%0d exp=%0d", rel, rd_addr, ea);
                end
            end
            if (rel >= 3 && rel <= n + 2) begin
                k  = rel - 3;
                ea = 14'(wb + k * 4);
                ew = model_word(md, bk, fs, mem[14'(rb + k * 4)]);
                last_out = ew;
                n_checks++;
                if (wr_addr !== ea) begin
                    n_fail++;
                    $display("FAIL wr_addr rel=%0d got=%0d exp=%0d", rel, wr_addr, ea);
                end
            end
            n_checks++;
            if (output_word !== last_out) begin
                n_fail++;
                $display("FAIL output_word rel=%0d got=%h exp=%h", rel, output_word, last_out);
            end
        end
    endtask

    task automatic test_reset();
        reset = 1'b1;
        repeat (3) @(negedge clk);
        n_checks++;
        if ({rd_en, busy, done, wr_en} !== 4'b0000) begin
            n_fail++;
            $display("FAIL reset_ctrl got=%b exp=0000", {rd_en, busy, done, wr_en});
        end
        n_checks++;
        if (rd_addr !== '0 || wr_addr !== '0) begin
            n_fail++;
            $display("FAIL reset_addr got rd=%0d wr=%0d exp=0", rd_addr, wr_addr);
        end
        n_checks++;
        if (output_word !== '0) begin
            n_fail++;
            $display("FAIL reset_out got=%h exp=0", output_word);
        end
        reset = 1'b0;
    endtask

    task automatic test_relu();
        mem[0] = 32'h8007_00FB;
        run_job(1, 0, 8, 0, 0, 0, 1'b0);
        n_checks++;
        if (output_word !== 32'h0007_0000) begin
            n_fail++;
            $display("FAIL relu_vector got=%h exp=00070000", output_word);
        end
        run_job(6, int'($urandom_range(0, 16383)), int'($urandom_range(0, 16383)), 0, 0, 0, 1'b0);
        run_job(4, 16380, 16376, 0, 0, 0, 1'b0);
        run_job(5, int'($urandom_range(0, 16383)), 40, 2, 1, 3, 1'b0);
        run_job(5, int'($urandom_range(0, 16383)), 80, 3, 0, 0, 1'b0);
    endtask

    task automatic test_pwl_clamp();
        lut_write(0, -64);
        lut_write(1, 64);
        lut_write(2, 0);
        lut_write(3, 127);
        mem[100] = 32'h6440_C09C;
        run_job(1, 100, 200, 1, 0, 0, 1'b0);
        n_checks++;
        if (output_word !== 32'h7F7F_0000) begin
            n_fail++;
            $display("FAIL pwl_clamp got=%h exp=7f7f0000", output_word);
        end
    endtask

    task automatic test_pwl_segment();
        for (int i = 0; i < NS; i++) begin
            lut_write(4 + i, -64 + 16 * i);
            lut_write(4 + NS + i, (i == 4) ? 2 : rand_s8());
            lut_write(4 + 2*NS + i, (i == 4) ? 3 : rand_s8());
        end
        mem[300] = 32'h0505_0505;
        run_job(1, 300, 400, 1, 0, 1, 1'b0);
        n_checks++;
        if (output_word !== 32'h0808_0808) begin
            n_fail++;
            $display("FAIL pwl_segment got=%h exp=08080808", output_word);
        end
        for (int i = 0; i < NS; i++) begin
            lut_write(4 + NS + i, 127);
            lut_write(4 + 2*NS + i, 0);
        end
        mem[304] = 32'hF60A_F60A;
        run_job(2, 300, 400, 1, 0, 0, 1'b0);
        n_checks++;
        if (output_word !== 32'h807F_807F) begin
            n_fail++;
            $display("FAIL pwl_saturate got=%h exp=807f807f", output_word);
        end
        rand_bank(1);
        for (int r = 0; r < 3; r++)
            run_job(20, int'($urandom_range(0, 16383)), int'($urandom_range(0, 16383)),
                    1, 1, int'($urandom_range(0, 15)), 1'b0);
        rand_bank(0);
        run_job(12, int'($urandom_range(0, 16383)), 1000, 1, 0, int'($urandom_range(0, 7)), 1'b0);
    endtask

    task automatic test_timing();
        run_job(3, 0, 64, 2, 0, 0, 1'b0);
        run_job(0, 0, 64, 0, 0, 0, 1'b0);
        run_job(2, 12, 96, 0, 0, 0, 1'b0);
    endtask

    task automatic test_ignored();
        lut_write(BSZ + 0, -100);
        lut_write(BSZ + 1, 100);
        lut_write(BSZ + 2, -50);
        lut_write(BSZ + 3, 90);
        for (int i = 0; i < NS; i++) begin
            lut_write(BSZ + 4 + i, (i < 5) ? -80 + 20 * i : 15 * (i - 4));
            lut_write(BSZ + 4 + NS + i, (i == 5) ? 3 : 1);
            lut_write(BSZ + 4 + 2*NS + i, (i == 5) ? -4 : 0);
        end
        mem[500] = 32'h1414_1414;
        run_job(3, 500, 600, 1, 1, 0, 1'b1);
        run_job(1, 500, 700, 1, 1, 0, 1'b0);
        n_checks++;
        if (output_word !== 32'h3838_3838) begin
            n_fail++;
            $display("FAIL dropped_lut_write got=%h exp=38383838", output_word);
        end
    endtask

    task automatic test_reset_abort();
        @(negedge clk);
        num_words    = 16'd5;
        rd_base_addr = '0;
        wr_base_addr = 14'd64;
        mode         = 2'd2;
        start        = 1'b1;
        @(negedge clk);
        start = 1'b0;
        @(negedge clk);
        reset = 1'b1;
        @(negedge clk);
        reset = 1'b0;
        n_checks++;
        if ({rd_en, busy, done, wr_en} !== 4'b0000) begin
            n_fail++;
            $display("FAIL abort_ctrl rd/busy/done/wr got=%b exp=0000", {rd_en, busy, done, wr_en});
        end
        for (int c = 0; c < 8; c++) begin
            @(negedge clk);
            n_checks++;
            if (done !== 1'b0 || busy !== 1'b0) begin
                n_fail++;
                $display("FAIL abort_quiet cycle=%0d got done=%b busy=%b exp=0", c, done, busy);
            end
        end
        for (int b = 0; b < NF; b++)
            for (int e = 0; e < BSZ; e++) tbl_m[b][e] = 0;
        last_out = '0;
        mem[800] = 32'h0101_0101;
        run_job(1, 800, 900, 1, 0, 0, 1'b0);
        n_checks++;
        if (output_word !== 32'h0) begin
            n_fail++;
            $display("FAIL tables_cleared got=%h exp=0", output_word);
        end
        run_job(4, int'($urandom_range(0, 16383)), 300, 0, 0, 0, 1'b0);
    endtask

    initial begin
        for (int i = 0; i < 16384; i++) mem[i] = $urandom;
        for (int b = 0; b < NF; b++)
            for (int e = 0; e < BSZ; e++) tbl_m[b][e] = 0;
        test_reset();
        test_relu();
        test_pwl_clamp();
        test_pwl_segment();
        test_timing();
        test_ignored();
        test_reset_abort();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL watchdog expired before end of test");
        $fatal(1, "watchdog");
    end

endmodule
